sram_arb: RTL
=============

Name: sram_arb

Overview:
- Parametrised successor to the single-port sram: one word-addressed memory array shared by NUM_CH requesters (e.g. CPU fetch, CPU data, program/score loader).
- A round-robin arbiter grants at most one access per cycle.
- Reads return through a configurable-latency pipeline tagged by a one-hot channel valid.
- Replaces the direct CPU-to-sram connection so that a loader can fill memory while the CPU runs.

Parameters:
ADDR_WIDTH, 12, word address width
WORD_DEPTH, 4096, number of words (must be <= 2**ADDR_WIDTH)
WORD_WIDTH, 16, data word width
NUM_CH, 2, number of requesting channels (1..8)
RD_LATENCY, 1, cycles from the granted read edge to o_rvalid (1..4)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
i_req  input  NUM_CH  per-channel request, held until granted
i_we  input  NUM_CH  per-channel write (1) / read (0)
i_addr  input  NUM_CH*ADDR_WIDTH  packed addresses; channel k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH]
i_data  input  NUM_CH*WORD_WIDTH  packed write data, packed the same way
o_gnt  output  NUM_CH  one-hot grant, combinational from i_req and the priority pointer
o_rvalid  output  NUM_CH  one-hot, single-cycle read-data valid for the owning channel
o_data  output  WORD_WIDTH  read data, valid when any o_rvalid bit is set

Behaviour:
- Arbitration:
  - o_gnt selects the first requesting channel at or after ptr, searching upward with wrap-around.
  - o_gnt is all-zero when i_req is 0.
  - A transfer occurs at the rising edge where i_req[k] and o_gnt[k] are both 1.
  - ptr is a registered index. After a transfer on channel k, ptr <= (k+1) mod NUM_CH. With no transfer, ptr holds.
  - Requesters hold i_req, i_we, i_addr and i_data stable until they are granted.
- Write:
  - mem[addr] <= data at the grant edge.
  - No o_rvalid pulse for writes.
- Read:
  - mem[addr] is sampled at the grant edge.
  - o_data / o_rvalid[k] appear RD_LATENCY cycles after that edge.
  - o_rvalid is asserted for exactly one cycle per read.
- The pipeline is RD_LATENCY stages of {valid one-hot, data}. It accepts one read per cycle, so back-to-back reads give back-to-back o_rvalid pulses.
- When no read completes, o_data holds its last value and o_rvalid is 0.
- Read-after-write ordering:
  - A read granted in any cycle after a write to the same address returns the new data.
  - A read and a write never happen in the same cycle, so read/write collision does not arise.
- Out-of-range address (addr >= WORD_DEPTH):
  - Write is dropped; memory is unchanged.
  - Read still completes with o_rvalid and o_data = 0.
  - Grant and ptr update normally.
- Reset (asynchronous, any time):
  - ptr = 0, o_rvalid = 0, o_data = 0, pipeline valid bits cleared.
  - In-flight reads are discarded; no o_rvalid pulse follows reset release.
  - Memory contents are NOT cleared (preload via $readmemb must survive reset).
  - o_gnt is still combinational during reset. No transfer takes place while reset is 1.
- NUM_CH = 1 degenerates to a single-port sram with o_gnt = i_req.
- Memory is a plain reg array named mem, so benches can preload and inspect it hierarchically.

Test Plan:
- Reset, then ch0 writes 16'h00AB to addr 99; ch0 reads addr 99 in the next cycle -> with RD_LATENCY=1, o_rvalid=2'b01 and o_data=16'h00AB one cycle after the read grant.
- Both channels request reads continuously (ch0 addr 100, ch1 addr 101, preloaded 5 and 7) -> grants alternate 01,10,01,10; o_rvalid alternates with o_data 5,7,5,7.
- ch1 only requesting for 3 cycles, then ch0 joins -> ch1 granted 3 times, then ch0 granted next because ptr = 0 after the ch1 transfer.
- RD_LATENCY=3: four back-to-back reads of addr 0..3 holding 10,20,30,40 -> o_rvalid high on 4 consecutive cycles starting 3 cycles after the first grant, with o_data 10,20,30,40.
- Read addr 4095 with WORD_DEPTH=4000 -> o_rvalid pulse with o_data=0; write 16'hFFFF to addr 4001 then read addr 4001 -> still 0; mem[3999] unchanged.
- RD_LATENCY=2: issue a read, assert reset 1 cycle later for 3 ns -> no o_rvalid ever appears; ptr=0; the value written to addr 50 before reset still reads back correctly after reset.

Source files
------------

// File: rtl/sram_arb.sv
// ---------------------------------------------------------------------------
// sram_arb: a single word-addressed memory array that NUM_CH requesters share.
// Each cycle a round-robin arbiter grants at most one access. Read data
// comes back through an RD_LATENCY-deep pipeline. A one-hot valid vector
// tags each returning word with the channel that asked for it.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   i_req     per-channel request, held until granted
//   i_we      per-channel write (1) / read (0)
//   i_addr    packed word addresses, channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   i_data    packed write data, channel k at [k*WORD_WIDTH +: WORD_WIDTH]
//   o_gnt     one-hot grant, combinational from i_req and the rr pointer
//   o_rvalid  one-hot, single-cycle read-data valid for the owning channel
//   o_data    read data, meaningful while any o_rvalid bit is set
//
// Handshake: a channel raises i_req[k] and holds i_req/i_we/i_addr/i_data
// stable. The transfer happens at the rising edge where i_req[k] and
// o_gnt[k] are both 1. The channel may change its inputs after that edge.
// Reads complete exactly RD_LATENCY cycles after that edge with a one-cycle
// o_rvalid[k] pulse. There is no back-pressure on the read return path.
// ---------------------------------------------------------------------------
module sram_arb #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_DEPTH = 4096,
    parameter int WORD_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH-1:0]                i_req,
    input  logic [NUM_CH-1:0]                i_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]     i_addr,
    input  logic [NUM_CH*WORD_WIDTH-1:0]     i_data,
    output logic [NUM_CH-1:0]                o_gnt,
    output logic [NUM_CH-1:0]                o_rvalid,
    output logic [WORD_WIDTH-1:0]            o_data
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // The depth is held with one extra bit so that WORD_DEPTH == 2**ADDR_WIDTH still fits.
    localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(WORD_DEPTH);

    // The array is deliberately not reset, so contents preloaded hierarchically survive reset.
    logic [WORD_WIDTH-1:0] mem [0:WORD_DEPTH-1];

    logic [PW-1:0]             ptr;
    logic [2*NUM_CH-1:0]       req2;
    logic [2*NUM_CH-1:0]       gnt2;
    logic [NUM_CH-1:0]         rot;
    logic [NUM_CH-1:0]         rot_g;
    logic [PW-1:0]             gnt_idx;
    logic                      xfer;
    logic                      sel_we;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [WORD_WIDTH-1:0]     sel_data;
    logic                      in_range;
    logic                      rd_xfer;

    logic [NUM_CH-1:0]         pv [RD_LATENCY];
    logic [WORD_WIDTH-1:0]     pd [RD_LATENCY];

    // Round-robin pick. Rotate the request vector so that ptr lands at bit 0,
    // keep only the lowest set bit, then rotate that bit back into place.
    always_comb begin
        req2  = {i_req, i_req} >> ptr;
        rot   = req2[NUM_CH-1:0];
        rot_g = rot & (~rot + NUM_CH'(1));
        gnt2  = {rot_g, rot_g} << ptr;
        o_gnt = gnt2[2*NUM_CH-1:NUM_CH];
    end

    // Mux out the granted channel's fields. o_gnt is one-hot or zero.
    always_comb begin
        gnt_idx  = '0;
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (o_gnt[i]) begin
                gnt_idx  = PW'(i);
                sel_we   = i_we[i];
                sel_addr = i_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = i_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    assign xfer     = |o_gnt;
    assign in_range = {1'b0, sel_addr} < DEPTH_V;
    assign rd_xfer  = xfer && !sel_we;

    // The memory write has no reset branch. No transfer is allowed while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && xfer && sel_we && in_range) begin
            mem[sel_addr] <= sel_data;
        end
    end

    // Read pipeline and arbitration pointer.
    // A stage's data moves only when its valid does, so the last stage keeps
    // the most recently completed word (o_data holds between reads).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                pv[s] <= '0;
                pd[s] <= '0;
            end
        end else begin
            pv[0] <= rd_xfer ? o_gnt : '0;
            if (rd_xfer) begin
                // An out-of-range read still completes and returns zero.
                pd[0] <= in_range ? mem[sel_addr] : '0;
            end
            for (int s = 1; s < RD_LATENCY; s++) begin
                pv[s] <= pv[s-1];
                if (|pv[s-1]) begin
                    pd[s] <= pd[s-1];
                end
            end
            if (xfer) begin
                ptr <= (gnt_idx == PW'(NUM_CH-1)) ? '0 : gnt_idx + PW'(1);
            end
        end
    end

    assign o_rvalid = pv[RD_LATENCY-1];
    assign o_data   = pd[RD_LATENCY-1];

endmodule
